// File: rtl/fmap_pingpong_buffer_if.sv
// ---------------------------------------------------------------------------
// fmap_pingpong_buffer_if
// Pixel-stream bus between a feature-map producer, the ping-pong buffer and
// the downstream consumer.
//   in_valid / in_ready / data_in     : write-side handshake and pixel
//   out_valid / out_ready / data_out  : read-side handshake and pixel
//   out_last                          : data_out is the final pixel of a frame
//   frames_buffered                   : complete frames held (0..2)
// master: the surrounding logic (drives the write side, consumes the read side)
// slave : the buffer itself
// ---------------------------------------------------------------------------
interface fmap_pingpong_buffer_if #(
    parameter int WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_last;
    logic [1:0]       frames_buffered;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_last, frames_buffered
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_last, frames_buffered
    );
endinterface

// File: rtl/fmap_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// fmap_pingpong_buffer
// Two-bank feature-map store. A full ROWS x COLS frame is written in raster
// order into one bank while the previously completed frame is replayed, in
// the same order, from the other bank.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : synchronous flush of pointers, flags and output valid
//   bus      : slave side of fmap_pingpong_buffer_if (handshakes, pixels,
//              out_last, frames_buffered)
// ---------------------------------------------------------------------------
module fmap_pingpong_buffer #(
    parameter int WIDTH = 9,
    parameter int ROWS  = 30,
    parameter int COLS  = 30
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    fmap_pingpong_buffer_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    // Pixel storage; contents are never reset.
    logic [WIDTH-1:0] r_mem [2][N];

    logic             r_wb;
    logic             r_rb;
    logic [AW-1:0]    r_wr_addr;
    logic [AW-1:0]    r_rd_addr;
    logic [1:0]       r_full;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_data_out;

    logic             w_in_ready;
    logic             w_wr_en;
    logic             w_wr_done;
    logic             w_load;
    logic             w_rd_done;
    logic [1:0]       w_full_nxt;

    // Writer only ever targets a non-full bank, reader only a full one, so a
    // frame completing on each side in the same cycle touches different banks.
    assign w_in_ready = !r_full[r_wb] && !i_clear;
    assign w_wr_en    = bus.in_valid && w_in_ready;
    assign w_wr_done  = w_wr_en && (r_wr_addr == LAST);
    assign w_load     = r_full[r_rb] && (!r_out_valid || bus.out_ready) && !i_clear;
    assign w_rd_done  = w_load && (r_rd_addr == LAST);

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wb] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rb] = 1'b0;
    end

    // ---- write stage: store accepted pixel ----
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wb][r_wr_addr] <= bus.data_in;
    end

    // ---- control: bank pointers, addresses, full flags, output valid ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_full      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (i_clear) begin
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_full      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;

            if (w_wr_en) begin
                if (w_wr_done) begin
                    r_wr_addr <= '0;
                    r_wb      <= ~r_wb;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_rd_done;
                if (w_rd_done) begin
                    r_rd_addr <= '0;
                    r_rb      <= ~r_rb;
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // ---- read stage: output pixel register (held on stall and on clear) ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_out <= '0;
        end else if (w_load) begin
            r_data_out <= r_mem[r_rb][r_rd_addr];
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_last        = r_out_last;
    assign bus.data_out        = r_data_out;
    assign bus.frames_buffered = {1'b0, r_full[0]} + {1'b0, r_full[1]};
endmodule

// File: doc/fmap_pingpong_buffer.md
# fmap_pingpong_buffer

Parametrised two-bank feature-map buffer for the convolution datapath. It accepts one full ROWS×COLS feature map as a raster-order pixel stream, then replays it in the same order. It generalises the fixed 30×30 single-frame store with configurable geometry, valid/ready handshakes on both sides, and ping-pong banking, so frame N+1 can be written while frame N is read. It sits between a layer's output stage and the next layer's line/window logic.

## Interface
- WIDTH, 9: pixel word width in bits.
- ROWS, 30: feature-map rows; ≥1.
- COLS, 30: feature-map columns; ≥1.
- N (localparam) = ROWS*COLS; AW (localparam) = max(1, $clog2(N)).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  data_in carries a pixel.
- in_ready  out  1  buffer can accept a pixel this cycle.
- data_in  in  WIDTH  input pixel, raster order.
- out_valid  out  1  data_out holds a pixel.
- out_ready  in  1  consumer takes data_out this cycle.
- data_out  out  WIDTH  output pixel, raster order.
- out_last  out  1  data_out is pixel N-1 of its frame.
- frames_buffered  out  2  number of complete frames held (0..2).

## Operation
- Storage: two banks of N words each, implemented as a register array. Contents are not reset.
- State:
  - write bank wb and write address wr_addr (0..N-1);
  - read bank rb and read address rd_addr;
  - full[1:0] flags.
- frames_buffered = full[0] + full[1], combinational.
- in_ready = !full[wb] && !clear, combinational.
- Write: a pixel is accepted when in_valid && in_ready.
  - mem[wb][wr_addr] <= data_in.
  - If wr_addr == N-1: set full[wb], toggle wb, set wr_addr to 0. Otherwise increment wr_addr.
- Output load condition: load = full[rb] && (!out_valid || out_ready) && !clear.
  - data_out <= mem[rb][rd_addr], out_valid <= 1, out_last <= (rd_addr == N-1).
  - If rd_addr == N-1: clear full[rb], toggle rb, set rd_addr to 0. Otherwise increment rd_addr.
- If out_valid && out_ready && !load: out_valid <= 0 and out_last <= 0. data_out holds its value.
- While out_valid && !out_ready, data_out and out_last are held stable.
- Simultaneous write-complete and read-complete in one cycle: allowed. They always target different banks because the writer only uses a non-full bank and the reader only a full one. Both flag updates take effect.
- A bank freed by read-complete is writable from the next cycle.
- clear: at the edge, wb, rb, wr_addr, rd_addr, full, out_valid and out_last all go to 0.
  - An input pixel in a clear cycle is not accepted (in_ready=0).
  - An output handshake in a clear cycle is discarded.
  - data_out is not cleared.
- ROWS=COLS=1: each accepted pixel completes a frame. out_last is 1 on every output.

## Timing
- Reset values: out_valid=0, out_last=0, data_out=0, frames_buffered=0, in_ready=1 (with clear low), all pointers and flags 0.
- Throughput: 1 pixel/cycle on each side, sustained indefinitely when out_ready stays high.
- Latency: last pixel of a frame accepted at edge E → full set at E → out_valid=1 with pixel 0 after edge E+1.
- Backpressure: with both banks full, in_ready=0. After the edge that loads pixel N-1 of frame rb, in_ready returns to 1.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost.

## Test plan
- Single frame, defaults: stream 0..899 with out_ready=1 → outputs 0..899 in order. out_valid rises one edge after input 899 is accepted. out_last=1 only with 899. frames_buffered goes 1→0.
- Ping-pong: hold out_ready=0 and offer 3 frames continuously → in_ready drops after 1800 accepts with frames_buffered=2. Raise out_ready → in_ready rises one cycle after frame-0 pixel 899 loads. All 2700 values exit in order with no gaps.
- Backpressure: random out_ready and random in_valid gaps over 5 frames → data_out/out_last stable while stalled. Output sequence equals input sequence; no drop or duplicate.
- Clear mid-stream: clear pulse after 450 pixels of frame 1 while frame 0 is half read → next cycle out_valid=0, frames_buffered=0. The following 900 inputs (1000..1899) come out as one frame, with out_last on 1899.
- Reset mid-read: rst_n low for 3 cycles mid-frame → outputs at reset values. A fresh 900-pixel frame then replays exactly.
- Geometry: ROWS=4, COLS=3 and ROWS=COLS=1 → out_last every 12 and every 1 outputs respectively. Ping-pong behaviour as above.
